// File: rtl/umi_req_arb.sv
// umi_req_arb: round-robin arbiter sharing one UMI request channel among N
// requesters, with a single registered output stage.
//
// Optional feature macro: UMI_ARB_LOCK_EN
//   defined   - the grant is held from a packet's first beat through its
//               EOM=1 beat, so packets never interleave on the output.
//   undefined - re-arbitrates every beat; for single-beat traffic only.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   umi_in_valid[N]      per-requester valid
//   umi_in_cmd/dstaddr/srcaddr/data  packed per requester (i at [i*W +: W])
//   umi_in_ready[N]      per-requester ready (at most one high)
//   umi_out_*            registered shared request channel
//   umi_out_ready        downstream ready
module umi_req_arb #(
  parameter int N      = 4,
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 128,
  parameter int EOMBIT = 22
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic          lock;
  logic [PW-1:0] lid;
  logic [PW-1:0] gnt;
  logic          gnt_vld;
  logic          free;
  logic          xfer;
  int            idx;

  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dstaddr;
  logic [AW-1:0] sel_srcaddr;
  logic [DW-1:0] sel_data;

  logic          vld_p1;
  logic [CW-1:0] cmd_p1;
  logic [AW-1:0] dstaddr_p1;
  logic [AW-1:0] srcaddr_p1;
  logic [DW-1:0] data_p1;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] g);
    return (int'(g) == N - 1) ? '0 : g + 1'b1;
  endfunction

  // Grant: locked owner wins outright, otherwise first valid from ptr upward.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (lock) begin
      gnt     = lid;
      gnt_vld = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld && umi_in_valid[PW'(idx)]) begin
          gnt     = PW'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign free = !vld_p1 || umi_out_ready;

  // While locked, ready is offered to the owner regardless of its valid.
  always_comb begin
    for (int i = 0; i < N; i++)
      umi_in_ready[i] = free && gnt_vld && (PW'(i) == gnt) && (lock || umi_in_valid[i]);
  end

  assign xfer        = |(umi_in_valid & umi_in_ready);
  assign sel_cmd     = umi_in_cmd[int'(gnt)*CW +: CW];
  assign sel_dstaddr = umi_in_dstaddr[int'(gnt)*AW +: AW];
  assign sel_srcaddr = umi_in_srcaddr[int'(gnt)*AW +: AW];
  assign sel_data    = umi_in_data[int'(gnt)*DW +: DW];

  // ---- stage p1: registered output channel ----
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      vld_p1     <= 1'b0;
      cmd_p1     <= '0;
      dstaddr_p1 <= '0;
      srcaddr_p1 <= '0;
      data_p1    <= '0;
    end else if (xfer) begin
      vld_p1     <= 1'b1;
      cmd_p1     <= sel_cmd;
      dstaddr_p1 <= sel_dstaddr;
      srcaddr_p1 <= sel_srcaddr;
      data_p1    <= sel_data;
    end else if (umi_out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

`ifdef UMI_ARB_LOCK_EN
  logic eom;
  assign eom = sel_cmd[EOMBIT];

  // Priority moves only at packet end; mid-packet beats pin the grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr  <= '0;
      lock <= 1'b0;
      lid  <= '0;
    end else if (xfer) begin
      if (eom) begin
        ptr  <= next_idx(gnt);
        lock <= 1'b0;
      end else begin
        lock <= 1'b1;
        lid  <= gnt;
      end
    end
  end
`else
  assign lock = 1'b0;
  assign lid  = '0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ptr <= '0;
    else if (xfer) ptr <= next_idx(gnt);
  end
`endif

  assign umi_out_valid   = vld_p1;
  assign umi_out_cmd     = cmd_p1;
  assign umi_out_dstaddr = dstaddr_p1;
  assign umi_out_srcaddr = srcaddr_p1;
  assign umi_out_data    = data_p1;

endmodule
